// File: rtl/cpu_types_pkg.sv
// Shared CPU scalar types used by the pipeline latch bank.
package cpu_types_pkg;
    typedef logic [4:0]  regbits_t;
    typedef logic [5:0]  opcode_t;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/pipe_reg.sv
// One pipeline latch: flush bubbles to zero, else enable loads, else hold.
module pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (en) begin
            q     <= d;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_latches.sv
// IF/ID, ID/EX, EX/MEM and MEM/WB latches with sticky halt and stall/flush counters.
module pipeline_latches
    import cpu_types_pkg::*;
#(
    parameter int IDEX_W  = 128,
    parameter int EXMEM_W = 96,
    parameter int MEMWB_W = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IFID_enable,
    input  logic               IDEX_enable,
    input  logic               EXMEM_enable,
    input  logic               MEMWB_enable,
    input  logic               IFID_flush,
    input  logic               IDEX_flush,
    input  logic               EXMEM_flush,
    input  word_t              if_instr,
    input  word_t              if_npc,
    input  logic [IDEX_W-1:0]  id_payload,
    input  regbits_t           id_wsel,
    input  opcode_t            id_op,
    input  logic [EXMEM_W-1:0] ex_payload,
    input  regbits_t           ex_wsel,
    input  opcode_t            ex_op,
    input  logic               ex_halt,
    input  logic [MEMWB_W-1:0] mem_payload,
    output word_t              ifid_instr,
    output word_t              ifid_npc,
    output logic               ifid_valid,
    output logic [IDEX_W-1:0]  idex_payload,
    output regbits_t           idex_wsel,
    output opcode_t            idex_op,
    output logic               idex_valid,
    output logic [EXMEM_W-1:0] exmem_payload,
    output regbits_t           exmem_wsel,
    output opcode_t            exmem_op,
    output logic               exmem_halt,
    output logic               exmem_valid,
    output logic [MEMWB_W-1:0] memwb_payload,
    output regbits_t           memwb_wsel,
    output logic               memwb_valid,
    output logic               halt,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
);
    localparam int IFID_BITS  = 64;
    localparam int IDEX_BITS  = IDEX_W + 5 + 6;
    localparam int EXMEM_BITS = EXMEM_W + 5 + 6 + 1;
    localparam int MEMWB_BITS = MEMWB_W + 5 + 1 + 1;

    logic ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_fl, idex_fl, exmem_fl;
    logic memwb_loaded;
    logic memwb_carried_valid;
    logic memwb_carried_halt;

    // Once halted, every latch freezes regardless of the hazard unit.
    assign ifid_en  = IFID_enable  & ~halt;
    assign idex_en  = IDEX_enable  & ~halt;
    assign exmem_en = EXMEM_enable & ~halt;
    assign memwb_en = MEMWB_enable & ~halt;
    assign ifid_fl  = IFID_flush   & ~halt;
    assign idex_fl  = IDEX_flush   & ~halt;
    assign exmem_fl = EXMEM_flush  & ~halt;

    pipe_reg #(.W(IFID_BITS)) u_ifid (
        .clk   (CLK),
        .rst   (RST),
        .en    (ifid_en),
        .flush (ifid_fl),
        .d     ({if_instr, if_npc}),
        .q     ({ifid_instr, ifid_npc}),
        .valid (ifid_valid)
    );

    pipe_reg #(.W(IDEX_BITS)) u_idex (
        .clk   (CLK),
        .rst   (RST),
        .en    (idex_en),
        .flush (idex_fl),
        .d     ({id_payload, id_wsel, id_op}),
        .q     ({idex_payload, idex_wsel, idex_op}),
        .valid (idex_valid)
    );

    pipe_reg #(.W(EXMEM_BITS)) u_exmem (
        .clk   (CLK),
        .rst   (RST),
        .en    (exmem_en),
        .flush (exmem_fl),
        .d     ({ex_payload, ex_wsel, ex_op, ex_halt}),
        .q     ({exmem_payload, exmem_wsel, exmem_op, exmem_halt}),
        .valid (exmem_valid)
    );

    // MEM/WB carries the EX/MEM valid and halt along so bubbles stay bubbles.
    pipe_reg #(.W(MEMWB_BITS)) u_memwb (
        .clk   (CLK),
        .rst   (RST),
        .en    (memwb_en),
        .flush (1'b0),
        .d     ({mem_payload, exmem_wsel, exmem_valid, exmem_halt}),
        .q     ({memwb_payload, memwb_wsel, memwb_carried_valid, memwb_carried_halt}),
        .valid (memwb_loaded)
    );

    assign memwb_valid = memwb_loaded & memwb_carried_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt <= 1'b0;
        end else if (memwb_valid && memwb_carried_halt) begin
            halt <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!IFID_enable && !IFID_flush && !halt && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            // Counted once per cycle, however many latches flush together.
            if ((IFID_flush || IDEX_flush || EXMEM_flush) && !halt && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_latches.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor checks after each edge or reset.
module tb_pipeline_latches;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          IFID_enable, IDEX_enable, EXMEM_enable, MEMWB_enable;
    logic          IFID_flush, IDEX_flush, EXMEM_flush;
    logic [31:0]   if_instr, if_npc;
    logic [127:0]  id_payload;
    logic [4:0]    id_wsel;
    logic [5:0]    id_op;
    logic [95:0]   ex_payload;
    logic [4:0]    ex_wsel;
    logic [5:0]    ex_op;
    logic          ex_halt;
    logic [63:0]   mem_payload;
    logic [31:0]   ifid_instr, ifid_npc;
    logic          ifid_valid;
    logic [127:0]  idex_payload;
    logic [4:0]    idex_wsel;
    logic [5:0]    idex_op;
    logic          idex_valid;
    logic [95:0]   exmem_payload;
    logic [4:0]    exmem_wsel;
    logic [5:0]    exmem_op;
    logic          exmem_halt, exmem_valid;
    logic [63:0]   memwb_payload;
    logic [4:0]    memwb_wsel;
    logic          memwb_valid;
    logic          halt;
    logic [15:0]   stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int F_IFID_INSTR = 0,  F_IFID_NPC = 1,  F_IFID_VALID = 2;
    localparam int F_IDEX_PAY   = 3,  F_IDEX_WSEL = 4, F_IDEX_OP = 5,  F_IDEX_VALID = 6;
    localparam int F_EXMEM_PAY  = 7,  F_EXMEM_WSEL = 8, F_EXMEM_OP = 9, F_EXMEM_HALT = 10, F_EXMEM_VALID = 11;
    localparam int F_MEMWB_PAY  = 12, F_MEMWB_WSEL = 13, F_MEMWB_VALID = 14;
    localparam int F_HALT = 15, F_STALL = 16, F_FLUSH = 17, F_NUM = 18;

    typedef struct {
        string        tag;
        int           fld;
        logic [127:0] val;
    } item_t;
    item_t sb[$];

    pipeline_latches dut (
        .CLK(clk), .RST(rst),
        .IFID_enable(IFID_enable), .IDEX_enable(IDEX_enable),
        .EXMEM_enable(EXMEM_enable), .MEMWB_enable(MEMWB_enable),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
        .if_instr(if_instr), .if_npc(if_npc),
        .id_payload(id_payload), .id_wsel(id_wsel), .id_op(id_op),
        .ex_payload(ex_payload), .ex_wsel(ex_wsel), .ex_op(ex_op), .ex_halt(ex_halt),
        .mem_payload(mem_payload),
        .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
        .idex_payload(idex_payload), .idex_wsel(idex_wsel), .idex_op(idex_op), .idex_valid(idex_valid),
        .exmem_payload(exmem_payload), .exmem_wsel(exmem_wsel), .exmem_op(exmem_op),
        .exmem_halt(exmem_halt), .exmem_valid(exmem_valid),
        .memwb_payload(memwb_payload), .memwb_wsel(memwb_wsel), .memwb_valid(memwb_valid),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] actual(int fld);
        case (fld)
            F_IFID_INSTR:  return 128'(ifid_instr);
            F_IFID_NPC:    return 128'(ifid_npc);
            F_IFID_VALID:  return 128'(ifid_valid);
            F_IDEX_PAY:    return idex_payload;
            F_IDEX_WSEL:   return 128'(idex_wsel);
            F_IDEX_OP:     return 128'(idex_op);
            F_IDEX_VALID:  return 128'(idex_valid);
            F_EXMEM_PAY:   return 128'(exmem_payload);
            F_EXMEM_WSEL:  return 128'(exmem_wsel);
            F_EXMEM_OP:    return 128'(exmem_op);
            F_EXMEM_HALT:  return 128'(exmem_halt);
            F_EXMEM_VALID: return 128'(exmem_valid);
            F_MEMWB_PAY:   return 128'(memwb_payload);
            F_MEMWB_WSEL:  return 128'(memwb_wsel);
            F_MEMWB_VALID: return 128'(memwb_valid);
            F_HALT:        return 128'(halt);
            F_STALL:       return 128'(stall_cnt);
            default:       return 128'(flush_cnt);
        endcase
    endfunction

    function automatic string fname(int fld);
        case (fld)
            F_IFID_INSTR:  return "ifid_instr";
            F_IFID_NPC:    return "ifid_npc";
            F_IFID_VALID:  return "ifid_valid";
            F_IDEX_PAY:    return "idex_payload";
            F_IDEX_WSEL:   return "idex_wsel";
            F_IDEX_OP:     return "idex_op";
            F_IDEX_VALID:  return "idex_valid";
            F_EXMEM_PAY:   return "exmem_payload";
            F_EXMEM_WSEL:  return "exmem_wsel";
            F_EXMEM_OP:    return "exmem_op";
            F_EXMEM_HALT:  return "exmem_halt";
            F_EXMEM_VALID: return "exmem_valid";
            F_MEMWB_PAY:   return "memwb_payload";
            F_MEMWB_WSEL:  return "memwb_wsel";
            F_MEMWB_VALID: return "memwb_valid";
            F_HALT:        return "halt";
            F_STALL:       return "stall_cnt";
            default:       return "flush_cnt";
        endcase
    endfunction

    // Monitor: outputs are presented after each rising edge and immediately on reset.
    initial begin
        item_t        it;
        logic [127:0] act;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            while (sb.size() > 0) begin
                it  = sb.pop_front();
                act = actual(it.fld);
                n_cmp++;
                if (act !== it.val) begin
                    n_bad++;
                    $display("FAIL %s.%s got %h want %h", it.tag, fname(it.fld), act, it.val);
                end
            end
        end
    end

    task automatic expect_f(input string tag, input int fld, input logic [127:0] v);
        item_t it;
        it.tag = tag;
        it.fld = fld;
        it.val = v;
        sb.push_back(it);
    endtask

    task automatic expect_all_zero(input string tag);
        for (int f = 0; f < F_NUM; f++) expect_f(tag, f, '0);
    endtask

    task automatic defaults();
        IFID_enable = 1'b1; IDEX_enable = 1'b1; EXMEM_enable = 1'b1; MEMWB_enable = 1'b1;
        IFID_flush = 1'b0; IDEX_flush = 1'b0; EXMEM_flush = 1'b0;
        if_instr = '0; if_npc = '0; id_payload = '0; id_wsel = '0; id_op = '0;
        ex_payload = '0; ex_wsel = '0; ex_op = '0; ex_halt = 1'b0; mem_payload = '0;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        defaults();
        #2;
        expect_all_zero("reset_init");
        rst = 1'b1;
        next();

        // Load
        defaults(); rst = 1'b0;
        if_instr = 32'h8C22_0004; if_npc = 32'h0000_0104;
        expect_f("load", F_IFID_INSTR, 128'h8C22_0004);
        expect_f("load", F_IFID_NPC, 128'h104);
        expect_f("load", F_IFID_VALID, 128'd1);
        expect_f("load", F_IDEX_VALID, 128'd1);
        expect_f("load", F_STALL, 128'd0);
        expect_f("load", F_FLUSH, 128'd0);
        next();

        defaults();
        if_instr = 32'h0043_0820;
        id_payload = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        id_wsel = 5'd9; id_op = 6'h23;
        expect_f("idex_load", F_IFID_INSTR, 128'h0043_0820);
        expect_f("idex_load", F_IDEX_PAY, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        expect_f("idex_load", F_IDEX_WSEL, 128'd9);
        expect_f("idex_load", F_IDEX_OP, 128'h23);
        expect_f("idex_load", F_IDEX_VALID, 128'd1);
        next();

        // Flush beats enable
        defaults();
        IDEX_flush = 1'b1; id_wsel = 5'd9; id_payload = 128'hFFFF;
        ex_wsel = 5'd7; ex_op = 6'h2B; ex_payload = 96'hAAAA_0000_5555;
        expect_f("priority", F_IDEX_WSEL, 128'd0);
        expect_f("priority", F_IDEX_VALID, 128'd0);
        expect_f("priority", F_IDEX_PAY, 128'd0);
        expect_f("priority", F_FLUSH, 128'd1);
        expect_f("priority", F_EXMEM_WSEL, 128'd7);
        expect_f("priority", F_EXMEM_OP, 128'h2B);
        expect_f("priority", F_EXMEM_PAY, 128'hAAAA_0000_5555);
        expect_f("priority", F_EXMEM_VALID, 128'd1);
        next();

        // Triple flush counts once; MEM/WB captures the pre-flush EX/MEM contents
        defaults();
        IFID_flush = 1'b1; IDEX_flush = 1'b1; EXMEM_flush = 1'b1;
        if_instr = 32'h1234_5678; ex_wsel = 5'd5;
        mem_payload = 64'hDEAD_BEEF_0000_0001;
        expect_f("multi_flush", F_IFID_INSTR, 128'd0);
        expect_f("multi_flush", F_IFID_VALID, 128'd0);
        expect_f("multi_flush", F_IDEX_VALID, 128'd0);
        expect_f("multi_flush", F_EXMEM_WSEL, 128'd0);
        expect_f("multi_flush", F_EXMEM_VALID, 128'd0);
        expect_f("multi_flush", F_FLUSH, 128'd2);
        expect_f("multi_flush", F_STALL, 128'd0);
        expect_f("multi_flush", F_MEMWB_WSEL, 128'd7);
        expect_f("multi_flush", F_MEMWB_VALID, 128'd1);
        expect_f("multi_flush", F_MEMWB_PAY, 128'hDEAD_BEEF_0000_0001);
        next();

        defaults();
        mem_payload = 64'h1;
        expect_f("bubble_wb", F_MEMWB_VALID, 128'd0);
        expect_f("bubble_wb", F_MEMWB_WSEL, 128'd0);
        expect_f("bubble_wb", F_MEMWB_PAY, 128'd1);
        next();

        // Stall
        defaults();
        if_instr = 32'h8C22_0004; if_npc = 32'h0000_0200;
        expect_f("pre_stall", F_IFID_INSTR, 128'h8C22_0004);
        next();
        for (int i = 1; i <= 3; i++) begin
            defaults();
            IFID_enable = 1'b0; if_instr = 32'hFFFF_FFFF; if_npc = 32'hFFFF_FFFF;
            expect_f("stall", F_IFID_INSTR, 128'h8C22_0004);
            expect_f("stall", F_IFID_NPC, 128'h200);
            expect_f("stall", F_IFID_VALID, 128'd1);
            expect_f("stall", F_STALL, 128'(i));
            next();
        end

        defaults();
        IFID_enable = 1'b0; IFID_flush = 1'b1;
        expect_f("flush_no_stall", F_STALL, 128'd3);
        expect_f("flush_no_stall", F_FLUSH, 128'd3);
        expect_f("flush_no_stall", F_IFID_VALID, 128'd0);
        expect_f("flush_no_stall", F_IFID_INSTR, 128'd0);
        next();

        // Saturation: starts at 3, reaches FFFF after 65532 more stalls
        for (int i = 1; i <= 65540; i++) begin
            defaults();
            IFID_enable = 1'b0;
            if (i == 65531) expect_f("sat_m1", F_STALL, 128'hFFFE);
            if (i == 65532) expect_f("sat_hit", F_STALL, 128'hFFFF);
            if (i == 65540) begin
                id_wsel = 5'd12; ex_wsel = 5'd3; mem_payload = 64'h77;
                expect_f("sat_hold", F_STALL, 128'hFFFF);
                expect_f("sat_hold", F_IDEX_WSEL, 128'd12);
                expect_f("sat_hold", F_FLUSH, 128'd3);
            end
            next();
        end

        // Asynchronous reset between edges, mid-stall
        #2;
        expect_all_zero("async_rst");
        rst = 1'b1;
        next();

        defaults(); rst = 1'b0;
        IFID_enable = 1'b0; IDEX_flush = 1'b1; id_wsel = 5'd9;
        expect_f("post_rst", F_STALL, 128'd1);
        expect_f("post_rst", F_FLUSH, 128'd1);
        expect_f("post_rst", F_IFID_VALID, 128'd0);
        expect_f("post_rst", F_IFID_INSTR, 128'd0);
        expect_f("post_rst", F_IDEX_VALID, 128'd0);
        expect_f("post_rst", F_IDEX_WSEL, 128'd0);
        next();

        // Halt
        defaults();
        ex_halt = 1'b1; ex_wsel = 5'd4;
        expect_f("halt1", F_EXMEM_HALT, 128'd1);
        expect_f("halt1", F_EXMEM_VALID, 128'd1);
        expect_f("halt1", F_HALT, 128'd0);
        next();

        defaults();
        mem_payload = 64'hCAFE_F00D;
        expect_f("halt2", F_MEMWB_WSEL, 128'd4);
        expect_f("halt2", F_MEMWB_VALID, 128'd1);
        expect_f("halt2", F_MEMWB_PAY, 128'hCAFE_F00D);
        expect_f("halt2", F_EXMEM_HALT, 128'd0);
        expect_f("halt2", F_HALT, 128'd0);
        next();

        defaults();
        if_instr = 32'h2222_2222; id_wsel = 5'd17;
        expect_f("halt3", F_HALT, 128'd1);
        expect_f("halt3", F_IFID_INSTR, 128'h2222_2222);
        expect_f("halt3", F_IDEX_WSEL, 128'd17);
        next();

        defaults();
        IFID_flush = 1'b1; IDEX_flush = 1'b1; EXMEM_flush = 1'b1;
        if_instr = 32'h3333_3333; id_wsel = 5'd9; mem_payload = 64'h99;
        expect_f("frozen", F_IFID_INSTR, 128'h2222_2222);
        expect_f("frozen", F_IFID_VALID, 128'd1);
        expect_f("frozen", F_IDEX_WSEL, 128'd17);
        expect_f("frozen", F_IDEX_VALID, 128'd1);
        expect_f("frozen", F_MEMWB_PAY, 128'd0);
        expect_f("frozen", F_FLUSH, 128'd1);
        expect_f("frozen", F_HALT, 128'd1);
        next();

        defaults();
        IFID_enable = 1'b0; if_instr = 32'h4444_4444;
        expect_f("frozen_stall", F_STALL, 128'd1);
        expect_f("frozen_stall", F_IFID_INSTR, 128'h2222_2222);
        expect_f("frozen_stall", F_HALT, 128'd1);
        next();

        next();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_latches.md
PIPELINE_LATCHES -- requirements
Module: pipeline_latches

Interface
REQ-001 SHALL have parameter IDEX_W, default 128, ID/EX payload width in bits.
REQ-002 SHALL have parameter EXMEM_W, default 96, EX/MEM payload width in bits.
REQ-003 SHALL have parameter MEMWB_W, default 64, MEM/WB payload width in bits.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, ports listed below.
REQ-005 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 IFID_enable, IDEX_enable, EXMEM_enable, MEMWB_enable  in  1 each  per-latch load enables from the hazard unit.
REQ-008 IFID_flush, IDEX_flush, EXMEM_flush  in  1 each  per-latch bubble requests from the hazard unit.
REQ-009 if_instr, if_npc  in  32 each  fetched instruction and PC+4.
REQ-010 id_payload in IDEX_W, id_wsel in 5, id_op in 6  decode-stage outputs.
REQ-011 ex_payload in EXMEM_W, ex_wsel in 5, ex_op in 6, ex_halt in 1  execute-stage outputs.
REQ-012 mem_payload  in  MEMWB_W  memory-stage output.
REQ-013 ifid_instr, ifid_npc (32 each), ifid_valid (1)  out  IF/ID contents.
REQ-014 idex_payload (IDEX_W), idex_wsel (5), idex_op (6), idex_valid (1)  out  ID/EX contents; idex_wsel feeds the hazard unit.
REQ-015 exmem_payload (EXMEM_W), exmem_wsel (5), exmem_op (6), exmem_halt (1), exmem_valid (1)  out  EX/MEM contents; exmem_wsel and exmem_op feed the hazard unit.
REQ-016 memwb_payload (MEMWB_W), memwb_wsel (5), memwb_valid (1)  out  MEM/WB contents.
REQ-017 halt  out  1  sticky processor halt.
REQ-018 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-019 Per latch per edge, priority SHALL be: flush -> bubble; else enable -> load; else hold.
REQ-020 A bubble SHALL set every field of the latch to zero, valid to 0 (zero instruction = NOP, wsel = 0 = $zero).
REQ-021 Flush SHALL take effect regardless of the latch's enable.
REQ-022 A load SHALL set valid to 1; latency input-to-output SHALL be exactly one cycle.
REQ-023 MEM/WB SHALL load mem_payload, exmem_wsel, exmem_valid and exmem_halt; it has no flush.
REQ-024 EX/MEM SHALL load ex_payload, ex_wsel, ex_op, ex_halt.
REQ-025 halt SHALL rise on the edge after MEM/WB captures exmem_halt=1 with exmem_valid=1, then stay 1 until reset.
REQ-026 While halt=1 all four latches SHALL hold regardless of enable/flush.
REQ-027 stall_cnt SHALL increment each cycle IFID_enable=0, IFID_flush=0, halt=0; saturate at 16'hFFFF.
REQ-028 flush_cnt SHALL increment once per cycle in which any flush is 1 and halt=0 (not once per flush); saturate at 16'hFFFF.
REQ-029 Simultaneous flush of multiple latches SHALL bubble each independently in the same edge.

Reset
REQ-030 On RST=1 every latch field, every valid, halt, stall_cnt and flush_cnt SHALL be 0 immediately, without waiting for CLK.
REQ-031 Reset asserted mid-stall or mid-flush SHALL discard all in-flight contents; first edge after release obeys REQ-019.

Structure
REQ-032 regbits_t (5), opcode_t (6), word_t (32) SHALL come from cpu_types_pkg; no new package types.
REQ-033 One sub-module SHALL be used: pipe_reg, parameterised width, with enable, flush, valid; instantiated four times (MEM/WB flush tied 0).

Verification
REQ-034 Load: if_instr=32'h8C220004, IFID_enable=1, edge -> ifid_instr=32'h8C220004, ifid_valid=1.
REQ-035 Priority: IDEX_enable=1, IDEX_flush=1, id_wsel=5'd9 -> idex_wsel=0, idex_valid=0, flush_cnt +1.
REQ-036 Stall: IFID_enable=0 for 3 cycles -> ifid_* held, stall_cnt=3.
REQ-037 Halt: ex_halt=1 loaded with enables high -> exmem_halt=1 next edge, halt=1 two edges later; latches then frozen despite enable/flush.
REQ-038 Saturation/reset: force stall 65540 cycles -> stall_cnt=16'hFFFF; assert RST between edges -> all outputs 0 before next CLK.
